// File: rtl/uart_loader.sv
// uart_loader: parses framed length/data/checksum byte packets from the UART and writes the words to memory
module uart_loader #(
    parameter int WORD_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] word_count
);
    typedef enum logic [3:0] {IDLE, LEN_L, D_H, D_L, WRITE, CS_H, CS_L, DONE, ERROR} state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    state_t state;
    logic [TW-1:0] tmo;
    logic [7:0] hi;
    logic [15:0] len, cs, rx_word;
    logic [ADDR_WIDTH-1:0] wc_next;
    logic waiting, tmo_hit;
    always_comb begin
        rx_word = {hi, byte_in};
        wc_next = word_count + 1'b1;
        waiting = state inside {LEN_L, D_H, D_L, CS_H, CS_L};
        tmo_hit = waiting && !byte_valid && tmo == TMO_LAST;
    end
    // en low behaves like reset but keeps the last packet's word count visible
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= ADDR_WIDTH'(BASE_ADDR);
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            cs       <= '0;
            tmo      <= '0;
            hi       <= '0;
            len      <= '0;
            if (rst) word_count <= '0;
        end else begin
            tmo <= (waiting && !byte_valid) ? tmo + 1'b1 : '0;
            if (tmo_hit) begin
                state    <= ERROR;
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= 2'd3;
            end else begin
                case (state)
                    IDLE: if (byte_valid) begin
                        len[15:8]  <= byte_in;
                        word_count <= '0;
                        cs         <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        state      <= LEN_L;
                    end
                    LEN_L: if (byte_valid) begin
                        len[7:0] <= byte_in;
                        state    <= ({len[15:8], byte_in} == 16'd0) ? CS_H : D_H;
                    end
                    D_H, CS_H: if (byte_valid) begin
                        hi    <= byte_in;
                        state <= (state == D_H) ? D_L : CS_L;
                    end
                    D_L: if (byte_valid) begin
                        mem_data <= WORD_WIDTH'(rx_word);
                        mem_addr <= ADDR_WIDTH'(BASE_ADDR) + word_count;
                        cs       <= cs + rx_word;
                        mem_req  <= 1'b1;
                        state    <= WRITE;
                    end
                    WRITE: begin
                        if (mem_ack) begin
                            word_count <= wc_next;
                            mem_req    <= 1'b0;
                            state      <= (32'(wc_next) < 32'(len)) ? D_H : CS_H;
                        end
                        // a byte arriving mid-write is an overrun even if the write completes now
                        if (byte_valid) begin
                            mem_req  <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= 2'd2;
                            state    <= ERROR;
                        end
                    end
                    CS_L: if (byte_valid) begin
                        busy     <= 1'b0;
                        done     <= (rx_word == cs);
                        error    <= (rx_word != cs);
                        err_code <= (rx_word == cs) ? 2'd0 : 2'd1;
                        state    <= (rx_word == cs) ? DONE : ERROR;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed and randomized packet loads against a word-level reference model
module tb_uart_loader;
    localparam int TMO = 100;
    localparam logic [15:0] BASE = 16'h0000;
    logic clk = 1'b0;
    logic rst, en, byte_valid, mem_ack, mem_req, busy, done, error;
    logic [7:0] byte_in;
    logic [15:0] mem_addr, mem_data, word_count;
    logic [1:0] err_code;
    int checks = 0, errors = 0;
    int ack_dly = 2;
    bit ack_on = 1'b1;
    int last_wc = 0;
    logic [31:0] obs[$];
    logic [15:0] words[$];

    uart_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .byte_in(byte_in), .byte_valid(byte_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_req && mem_ack) obs.push_back({mem_addr, mem_data});

    initial begin
        int cnt = 0;
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1 mem_ack = 1'b0;
            if (mem_req && ack_on) begin
                if (cnt >= ack_dly) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_write();
        int t = 0;
        while (mem_req && t < 50) begin
            @(posedge clk);
            #1 t++;
        end
        check("write_ack_wait", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic restart();
        en = 1'b0;
        idle(1);
        check("en_low_done", {31'd0, done}, 32'd0);
        check("en_low_error", {31'd0, error}, 32'd0);
        check("en_low_wc_held", {16'd0, word_count}, 32'(last_wc));
        en = 1'b1;
    endtask

    // model: words land at consecutive addresses; checksum is their 16-bit sum
    task automatic run_packet(input logic [15:0] cs_xor, input string tag);
        logic [15:0] sum = 16'd0;
        logic [15:0] cs;
        logic [15:0] n = 16'(words.size());
        bit good = (cs_xor == 16'd0);
        foreach (words[i]) sum += words[i];
        cs = sum ^ cs_xor;
        obs.delete();
        send(n[15:8]);
        send(n[7:0]);
        foreach (words[i]) begin
            send(words[i][15:8]);
            send(words[i][7:0]);
            wait_write();
        end
        send(cs[15:8]);
        send(cs[7:0]);
        check({tag, "_done"}, {31'd0, done}, {31'd0, good});
        check({tag, "_error"}, {31'd0, error}, {31'd0, !good});
        check({tag, "_err_code"}, {30'd0, err_code}, good ? 32'd0 : 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_word_count"}, {16'd0, word_count}, {16'd0, n});
        check({tag, "_nwrites"}, obs.size(), {16'd0, n});
        foreach (words[i]) if (i < obs.size()) check({tag, "_write"}, obs[i], {BASE + 16'(i), words[i]});
        last_wc = int'(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; byte_valid = 1'b0; byte_in = 8'h00;
        idle(2);
        rst = 1'b0;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, {16'd0, BASE});
        check("rst_mem_data", {16'd0, mem_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_word_count", {16'd0, word_count}, 32'd0);

        words = {};
        words.push_back(16'h1234);
        words.push_back(16'hABCD);
        run_packet(16'h0000, "pkt_good");
        send(8'h77);
        check("sticky_done", {31'd0, done}, 32'd1);
        check("sticky_busy", {31'd0, busy}, 32'd0);

        restart();
        run_packet(16'h0003, "pkt_badcs");

        restart();
        words = {};
        run_packet(16'h0000, "pkt_empty");

        restart();
        ack_on = 1'b0;
        send(8'h00); send(8'h02); send(8'h11); send(8'h22);
        check("ovr_req_up", {31'd0, mem_req}, 32'd1);
        check("ovr_addr", {16'd0, mem_addr}, {16'd0, BASE});
        check("ovr_data", {16'd0, mem_data}, 32'h1122);
        send(8'h55);
        check("ovr_req_drop", {31'd0, mem_req}, 32'd0);
        check("ovr_error", {31'd0, error}, 32'd1);
        check("ovr_err_code", {30'd0, err_code}, 32'd2);
        check("ovr_busy", {31'd0, busy}, 32'd0);
        ack_on = 1'b1;
        last_wc = 0;

        restart();
        send(8'h00); send(8'h03);
        check("tmo_busy_before", {31'd0, busy}, 32'd1);
        idle(TMO - 1);
        check("tmo_not_yet", {31'd0, error}, 32'd0);
        idle(1);
        check("tmo_error", {31'd0, error}, 32'd1);
        check("tmo_err_code", {30'd0, err_code}, 32'd3);
        check("tmo_busy", {31'd0, busy}, 32'd0);

        restart();
        send(8'h00); send(8'h02); send(8'h12);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_addr", {16'd0, mem_addr}, {16'd0, BASE});
        check("mid_rst_data", {16'd0, mem_data}, 32'd0);
        check("mid_rst_err_code", {30'd0, err_code}, 32'd0);
        check("mid_rst_wc", {16'd0, word_count}, 32'd0);
        last_wc = 0;
        restart();
        words = {};
        words.push_back(16'h5A5A);
        words.push_back(16'h0F0F);
        run_packet(16'h0000, "pkt_after_rst");

        for (int k = 0; k < 12; k++) begin
            restart();
            ack_dly = $urandom_range(0, 3);
            words = {};
            for (int i = 0, n = $urandom_range(0, 5); i < n; i++) words.push_back(16'($urandom));
            run_packet(($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000, "pkt_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Program loader between the UART byte receiver and the CPU memory write port.
- Consumes the received byte stream, parses a framed packet (length header, data words, checksum) and writes the words to consecutive memory addresses over a req/ack handshake.
- Reports progress, completion and error status for the LEDs and the display.
- Replaces free-running word counting with framed, checked loads.

Parameters:
- WORD_WIDTH, 16, data word width; fixed at 2 bytes per word.
- ADDR_WIDTH, 16, memory address width.
- BASE_ADDR, 0, address of the first data word.
- TIMEOUT_CYCLES, 5000000, maximum idle clk cycles between bytes inside a packet (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous reset, active-high.
- en  in  1  load enable (SW[1]); low forces IDLE and clears status.
- byte_in  in  8  received byte; valid only when byte_valid is high.
- byte_valid  in  1  one-cycle pulse per received byte.
- mem_req  out  1  write request to memory.
- mem_addr  out  ADDR_WIDTH  write address; stable while mem_req is high.
- mem_data  out  WORD_WIDTH  write data; stable while mem_req is high.
- mem_ack  in  1  memory accepted the write this cycle.
- busy  out  1  packet in progress.
- done  out  1  packet loaded and checksum matched (sticky).
- error  out  1  load failed (sticky).
- err_code  out  2  0 none, 1 checksum mismatch, 2 overrun, 3 timeout.
- word_count  out  ADDR_WIDTH  data words written in the current or last packet.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; mem_req=0; mem_addr=BASE_ADDR; mem_data=0; busy=done=error=0; err_code=0; word_count=0; checksum accumulator=0; timeout counter=0.
- en=0: same as reset except word_count is held. Sampled every cycle; overrides all states, including a pending mem_req.
- Packet format, bytes are big-endian:
  - LEN_H, LEN_L: N, the number of data words.
  - N × (D_H, D_L): data words.
  - CS_H, CS_L: sum of all data words mod 2^16. The length field is not included in the sum.
- IDLE: first byte_valid with en=1 → LEN_H captured; word_count:=0; checksum:=0; busy:=1; done:=0; error:=0; next state LEN_L.
- LEN_L: capture the low byte. If N==0, go to CS_H; otherwise go to D_H.
- D_H: capture the high byte, then go to D_L.
- D_L: form the word. Then:
  - mem_data:=word; mem_addr:=BASE_ADDR+word_count (wraps mod 2^ADDR_WIDTH).
  - checksum+=word.
  - mem_req:=1 in the next cycle; state WRITE.
- WRITE:
  - Hold mem_req, mem_addr and mem_data until a cycle with mem_ack=1.
  - In that cycle the write completes and word_count increments.
  - mem_req is 0 in the following cycle.
  - Next state: D_H if word_count<N, otherwise CS_H.
  - mem_ack while mem_req=0 is ignored.
- byte_valid while in WRITE → overrun: mem_req drops next cycle; state ERROR with err_code=2. Words already written remain in memory.
- CS_H: capture the high byte, then go to CS_L.
- CS_L: compare the received checksum with the accumulator. Match → DONE (done=1, busy=0). Mismatch → ERROR with err_code=1.
- DONE / ERROR:
  - Sticky; busy=0.
  - Further bytes are ignored until en goes low, or rst.
- Timeout:
  - In LEN_L, D_H, D_L, CS_H and CS_L, the counter increments each cycle without byte_valid and clears on byte_valid.
  - Reaching TIMEOUT_CYCLES → ERROR with err_code=3.
  - The counter is held at 0 in IDLE and WRITE.
- Latency: the write request appears 1 cycle after the D_L byte_valid. done/error assert 1 cycle after the CS_L byte_valid.
- A byte_valid in the same cycle as mem_ack in WRITE is still an overrun; the write still counts.
- Simultaneous rst and en: rst wins.

Test Plan:
- Bytes 00 02 12 34 AB CD BE 01, mem_ack 2 cycles after each req → writes (0x0000,0x1234), (0x0001,0xABCD); done=1; word_count=2; err_code=0.
- Same packet with checksum BE 02 → both words written; error=1; err_code=1; done=0.
- Bytes 00 00 00 00 → no mem_req; done=1; word_count=0.
- mem_ack held low and a further byte sent during WRITE → mem_req drops next cycle; error=1; err_code=2.
- Bytes 00 03 then silence (TIMEOUT_CYCLES=100 in bench) → error at cycle 100 after the last byte; err_code=3; busy=0.
- rst pulse mid-data, then en low→high, then a valid packet → all outputs at reset values; the second packet loads from BASE_ADDR; done=1.
